// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: carries the GPR and HI/LO write requests into MEM, and holds the
// MADD/MSUB partial product and step count that EX reads back while it is stalled.
module ex_mem_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned EX_IDX  = 2,
  parameter int unsigned MEM_IDX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic [RADDR_W-1:0]    ex_rw,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  ex_whilo,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic [2*DATA_W-1:0]   ex_hilo_temp,
  input  logic [1:0]            ex_cnt,
  output logic [RADDR_W-1:0]    mem_rw,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_whilo,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic [2*DATA_W-1:0]   hilo_temp_o,
  output logic [1:0]            cnt_o
);

  logic ex_stall;
  logic mem_stall;
  logic unused_stall;

  assign ex_stall     = stall[EX_IDX];
  assign mem_stall    = stall[MEM_IDX];
  // Only the EX and MEM bits matter at this boundary.
  assign unused_stall = ^stall;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mem_rw      <= '0;
      mem_wreg    <= 1'b0;
      mem_wdata   <= '0;
      mem_whilo   <= 1'b0;
      mem_hi      <= '0;
      mem_lo      <= '0;
      hilo_temp_o <= '0;
      cnt_o       <= '0;
    end else if (ex_stall && mem_stall) begin
      mem_rw      <= mem_rw;
      mem_wreg    <= mem_wreg;
      mem_wdata   <= mem_wdata;
      mem_whilo   <= mem_whilo;
      mem_hi      <= mem_hi;
      mem_lo      <= mem_lo;
      hilo_temp_o <= hilo_temp_o;
      cnt_o       <= cnt_o;
    end else if (ex_stall) begin
      // Bubble into MEM while EX keeps its multi-cycle step result for the next cycle.
      mem_rw      <= '0;
      mem_wreg    <= 1'b0;
      mem_wdata   <= '0;
      mem_whilo   <= 1'b0;
      mem_hi      <= '0;
      mem_lo      <= '0;
      hilo_temp_o <= ex_hilo_temp;
      cnt_o       <= ex_cnt;
    end else begin
      mem_rw      <= ex_rw;
      mem_wreg    <= ex_wreg;
      mem_wdata   <= ex_wdata;
      mem_whilo   <= ex_whilo;
      mem_hi      <= ex_hi;
      mem_lo      <= ex_lo;
      hilo_temp_o <= '0;
      cnt_o       <= '0;
    end
  end

  // ctrl always stalls every earlier stage along with MEM.
  illegal_stall_a: assert property (@(posedge clk) disable iff (rst)
    !(stall[MEM_IDX] && !stall[EX_IDX]));

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios plus randomized legal stall/flush
// traffic, all checked against a per-edge behavioural model.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_rw;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [63:0] ex_hilo_temp;
  logic [1:0]  ex_cnt;
  logic [4:0]  mem_rw;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what MEM should see, and what EX should get back.
  logic [4:0]  m_rw;
  logic        m_wreg;
  logic [31:0] m_wdata;
  logic        m_whilo;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_temp;
  logic [1:0]  m_cnt;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .ex_rw        (ex_rw),
    .ex_wreg      (ex_wreg),
    .ex_wdata     (ex_wdata),
    .ex_whilo     (ex_whilo),
    .ex_hi        (ex_hi),
    .ex_lo        (ex_lo),
    .ex_hilo_temp (ex_hilo_temp),
    .ex_cnt       (ex_cnt),
    .mem_rw       (mem_rw),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_whilo    (mem_whilo),
    .mem_hi       (mem_hi),
    .mem_lo       (mem_lo),
    .hilo_temp_o  (hilo_temp_o),
    .cnt_o        (cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rw"},    64'(mem_rw),    64'(m_rw));
    check({tag, ".wreg"},  64'(mem_wreg),  64'(m_wreg));
    check({tag, ".wdata"}, 64'(mem_wdata), 64'(m_wdata));
    check({tag, ".whilo"}, 64'(mem_whilo), 64'(m_whilo));
    check({tag, ".hi"},    64'(mem_hi),    64'(m_hi));
    check({tag, ".lo"},    64'(mem_lo),    64'(m_lo));
    check({tag, ".temp"},  hilo_temp_o,    m_temp);
    check({tag, ".cnt"},   64'(cnt_o),     64'(m_cnt));
  endtask

  // One clock edge: apply the pipeline-boundary rules to the model, then compare.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst || flush) begin
      {m_rw, m_wreg, m_wdata, m_whilo, m_hi, m_lo, m_temp, m_cnt} = '0;
    end else if (stall[2] && stall[3]) begin
      // whole register frozen
    end else if (stall[2]) begin
      {m_rw, m_wreg, m_wdata, m_whilo, m_hi, m_lo} = '0;
      m_temp = ex_hilo_temp;
      m_cnt  = ex_cnt;
    end else begin
      m_rw    = ex_rw;
      m_wreg  = ex_wreg;
      m_wdata = ex_wdata;
      m_whilo = ex_whilo;
      m_hi    = ex_hi;
      m_lo    = ex_lo;
      m_temp  = '0;
      m_cnt   = '0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic rand_ex();
    ex_rw        = 5'($urandom);
    ex_wreg      = 1'($urandom);
    ex_wdata     = $urandom;
    ex_whilo     = 1'($urandom);
    ex_hi        = $urandom;
    ex_lo        = $urandom;
    ex_hilo_temp = {$urandom, $urandom};
    ex_cnt       = 2'($urandom);
  endtask

  initial begin
    {m_rw, m_wreg, m_wdata, m_whilo, m_hi, m_lo, m_temp, m_cnt} = '0;
    flush = 1'b0;
    stall = 6'b0;

    // Reset with every input nonzero.
    rst = 1'b1;
    ex_rw = 5'd31; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF; ex_whilo = 1'b1;
    ex_hi = 32'h1111_1111; ex_lo = 32'h2222_2222; ex_hilo_temp = 64'hFFFF_0000_FFFF_0000;
    ex_cnt = 2'd3; stall = 6'b000111; flush = 1'b1;
    for (int i = 0; i < 3; i++) step("reset");
    check("reset_wdata_zero", 64'(mem_wdata), 64'h0);

    rst = 1'b0; flush = 1'b0; stall = 6'b0;
    ex_wdata = 32'h1234_5678; ex_rw = 5'd8; ex_wreg = 1'b1;
    step("release");
    check("release_wdata", 64'(mem_wdata), 64'h1234_5678);
    check("release_rw", 64'(mem_rw), 64'd8);

    // HI/LO pass-through.
    ex_whilo = 1'b1; ex_hi = 32'hFFFF_FFFF; ex_lo = 32'h0000_0002;
    step("hilo");
    check("hilo_hi", 64'(mem_hi), 64'hFFFF_FFFF);
    check("hilo_lo", 64'(mem_lo), 64'h2);

    // MADD: step 1 under EX stall, step 2 advances.
    stall = 6'b000111; ex_hilo_temp = 64'h0000_0001_0000_0003; ex_cnt = 2'd1;
    step("madd1");
    check("madd1_temp", hilo_temp_o, 64'h0000_0001_0000_0003);
    check("madd1_cnt", 64'(cnt_o), 64'd1);
    check("madd1_wreg", 64'(mem_wreg), 64'd0);
    stall = 6'b0; ex_whilo = 1'b1; ex_hi = 32'd1; ex_lo = 32'd5;
    step("madd2");
    check("madd2_lo", 64'(mem_lo), 64'd5);
    check("madd2_cnt", 64'(cnt_o), 64'd0);

    // Full hold across 4 edges with moving EX inputs.
    ex_wdata = 32'hA5A5_A5A5;
    step("hold_load");
    stall = 6'b001111;
    for (int i = 0; i < 4; i++) begin
      rand_ex();
      step("hold");
      check("hold_wdata", 64'(mem_wdata), 64'hA5A5_A5A5);
    end

    // Flush while EX and MEM are both stalled.
    stall = 6'b000111; ex_hilo_temp = 64'h55; ex_cnt = 2'd1;
    step("pre_flush");
    check("pre_flush_temp", hilo_temp_o, 64'h55);
    stall = 6'b001111; flush = 1'b1; rand_ex();
    step("flush");
    check("flush_temp", hilo_temp_o, 64'h0);
    flush = 1'b0;

    // Back-to-back advance.
    stall = 6'b0;
    for (int i = 1; i <= 3; i++) begin
      ex_wdata = 32'(i);
      step("b2b");
      check("b2b_wdata", 64'(mem_wdata), 64'(i));
    end

    // Random legal traffic: stall vectors are always a prefix of stages.
    for (int i = 0; i < 400; i++) begin
      int k;
      k = $urandom_range(0, 6);
      stall = 6'((7'd1 << k) - 7'd1);
      flush = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      rand_ex();
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
